// File: rtl/gate_sequence_driver.sv
// gate_sequence_driver: loads a state vector and a gate list, then applies
// the gates one at a time through an external combinational multiplier.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   start, num_gates      run request (IDLE only) and requested gate count
//   load_valid/ready/data load stream: state words, then gate words
//   busy                  high whenever the FSM is not IDLE
//   mul_state, mul_gate   operands to the multiplier
//   mul_result            multiplier output, latched as the next state
//   out_valid/ready/data  readout stream of the final state vector
//   out_last              marks the final readout word
//
// Word packing: [31:16] real, [15:0] imag, each sign-magnitude Q1.14.
// Values are only stored and forwarded, never computed on.

module gate_sequence_driver #(
    parameter int N         = 2,
    parameter int MAX_GATES = 4,
    parameter int SETTLE    = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(MAX_GATES+1)-1:0]         num_gates,
    input  logic                                   load_valid,
    output logic                                   load_ready,
    input  logic [31:0]                            load_data,
    output logic                                   busy,
    output logic [(1<<N)-1:0][31:0]                mul_state,
    output logic [(1<<N)-1:0][(1<<N)-1:0][31:0]    mul_gate,
    input  logic [(1<<N)-1:0][31:0]                mul_result,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [31:0]                            out_data,
    output logic                                   out_last
);

    localparam int DIM  = 1 << N;
    localparam int DD   = DIM * DIM;
    localparam int MEMW = MAX_GATES * DD;
    localparam int AW   = (MEMW > 1) ? $clog2(MEMW) : 1;
    localparam int CW   = AW + 1;
    localparam int GW   = $clog2(MAX_GATES + 1);
    localparam int KW   = (N > 0) ? N : 1;
    localparam int SW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(DIM - 1);
    localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);
    localparam logic [GW-1:0] G_MAX    = GW'(MAX_GATES);
    localparam logic [CW-1:0] DD_C     = CW'(DD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_STATE,
        S_LOAD_GATES,
        S_APPLY,
        S_READOUT
    } state_e;

    state_e                    fsm_q, fsm_d;
    logic [DIM-1:0][31:0]      sv_q, sv_d;
    logic [KW-1:0]             k_q, k_d;
    logic [CW-1:0]             w_q, w_d;
    logic [GW-1:0]             g_q, g_d;
    logic [GW-1:0]             gnum_q, gnum_d;
    logic [SW-1:0]             cnt_q, cnt_d;
    logic [KW-1:0]             j_q, j_d;

    // Gate memory is plain storage: it is never read before being
    // written in the same run, so it carries no reset.
    logic [31:0]               gmem_q [MEMW];
    logic                      gmem_we;

    logic [CW-1:0]             gw_total;
    logic [CW-1:0]             gw_last;
    logic [AW-1:0]             gate_base;
    logic [DIM-1:0][DIM-1:0][31:0] gate_rd;
    logic [GW-1:0]             g_inc;

    assign gw_total  = CW'(gnum_q) * DD_C;
    assign gw_last   = gw_total - CW'(1);
    // Only used in APPLY, where g_q < MAX_GATES keeps this in range.
    assign gate_base = AW'(int'(g_q) * DD);
    assign g_inc     = g_q + GW'(1);

    always_comb begin
        gate_rd = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                gate_rd[r][c] = gmem_q[gate_base + AW'(r * DIM + c)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gmem_we) begin
            gmem_q[w_q[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q  <= S_IDLE;
            sv_q   <= '0;
            k_q    <= '0;
            w_q    <= '0;
            g_q    <= '0;
            gnum_q <= '0;
            cnt_q  <= '0;
            j_q    <= '0;
        end else begin
            fsm_q  <= fsm_d;
            sv_q   <= sv_d;
            k_q    <= k_d;
            w_q    <= w_d;
            g_q    <= g_d;
            gnum_q <= gnum_d;
            cnt_q  <= cnt_d;
            j_q    <= j_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        sv_d       = sv_q;
        k_d        = k_q;
        w_d        = w_q;
        g_d        = g_q;
        gnum_d     = gnum_q;
        cnt_d      = cnt_q;
        j_d        = j_q;
        gmem_we    = 1'b0;
        load_ready = 1'b0;
        mul_gate   = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;

        unique case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    gnum_d = (num_gates > G_MAX) ? G_MAX : num_gates;
                    k_d    = '0;
                    fsm_d  = S_LOAD_STATE;
                end
            end

            S_LOAD_STATE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    sv_d[k_q] = load_data;
                    k_d       = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        w_d = '0;
                        j_d = '0;
                        if (gnum_q != '0) begin
                            fsm_d = S_LOAD_GATES;
                        end else begin
                            fsm_d = S_READOUT;
                        end
                    end
                end
            end

            S_LOAD_GATES: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    gmem_we = 1'b1;
                    w_d     = w_q + CW'(1);
                    if (w_q == gw_last) begin
                        g_d   = '0;
                        cnt_d = '0;
                        fsm_d = S_APPLY;
                    end
                end
            end

            S_APPLY: begin
                mul_gate = gate_rd;
                if (cnt_q == SETTLE_C) begin
                    // Multiplier has had SETTLE extra cycles; take its result.
                    sv_d  = mul_result;
                    cnt_d = '0;
                    g_d   = g_inc;
                    if (g_inc == gnum_q) begin
                        j_d   = '0;
                        fsm_d = S_READOUT;
                    end
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end

            S_READOUT: begin
                out_valid = 1'b1;
                out_data  = sv_q[j_q];
                out_last  = (j_q == K_LAST);
                if (out_ready) begin
                    j_d = j_q + KW'(1);
                    if (j_q == K_LAST) begin
                        j_d   = '0;
                        fsm_d = S_IDLE;
                    end
                end
            end

            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (fsm_q != S_IDLE);
    assign mul_state = sv_q;

endmodule

// File: tb/tb_gate_sequence_driver.sv
// Testbench for gate_sequence_driver (N=2, MAX_GATES=4, SETTLE=1).
// Multiplier is a behavioural complex matrix-vector product.

module tb_gate_sequence_driver;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic [2:0]              num_gates;
    logic                    load_valid;
    logic                    load_ready;
    logic [31:0]             load_data;
    logic                    busy;
    logic [3:0][31:0]        mul_state;
    logic [3:0][3:0][31:0]   mul_gate;
    logic [3:0][31:0]        mul_result;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic                    out_last;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] st_in [4];
    int          gperm [8][4];
    logic [3:0]  gneg  [8];
    logic [31:0] exp_out [4];

    gate_sequence_driver #(
        .N         (2),
        .MAX_GATES (4),
        .SETTLE    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_gates  (num_gates),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .busy       (busy),
        .mul_state  (mul_state),
        .mul_gate   (mul_gate),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sm2i(input logic [15:0] v);
        return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
    endfunction

    function automatic logic [15:0] i2sm(input int v);
        int  m;
        logic s;
        s = (v < 0);
        m = s ? -v : v;
        if (m > 32767) m = 32767;
        if (m == 0) s = 1'b0;
        return {s, 15'(m)};
    endfunction

    function automatic logic [31:0] row_mult(input logic [3:0][31:0] grow,
                                             input logic [3:0][31:0] sv);
        int accr, acci, ar, ai, br, bi;
        accr = 0;
        acci = 0;
        for (int c = 0; c < 4; c++) begin
            ar = sm2i(grow[c][31:16]);
            ai = sm2i(grow[c][15:0]);
            br = sm2i(sv[c][31:16]);
            bi = sm2i(sv[c][15:0]);
            accr += ar * br - ai * bi;
            acci += ar * bi + ai * br;
        end
        return {i2sm(accr >>> 14), i2sm(acci >>> 14)};
    endfunction

    always_comb begin
        mul_result = '0;
        for (int r = 0; r < 4; r++) begin
            mul_result[r] = row_mult(mul_gate[r], mul_state);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cneg(input logic [31:0] x);
        logic [15:0] re, im;
        re = x[31:16];
        im = x[15:0];
        if (re[14:0] != 0) re[15] = ~re[15];
        if (im[14:0] != 0) im[15] = ~im[15];
        return {re, im};
    endfunction

    function automatic logic [31:0] rand_cx();
        logic [15:0] re, im;
        re = 16'($urandom);
        im = 16'($urandom);
        if (re[14:0] == 0) re[15] = 1'b0;
        if (im[14:0] == 0) im[15] = 1'b0;
        return {re, im};
    endfunction

    // Gate g is a signed permutation: row r has one entry at column
    // gperm[g][r], equal to -1.0 if gneg[g][r] else +1.0.
    function automatic logic [31:0] gate_word(input int g, input int idx);
        int r, c;
        r = idx / 4;
        c = idx % 4;
        if (c != gperm[g][r]) return 32'h0;
        return gneg[g][r] ? 32'hC000_0000 : 32'h4000_0000;
    endfunction

    task automatic set_xx(input int g);
        gperm[g] = '{3, 2, 1, 0};
        gneg[g]  = 4'b0000;
    endtask

    task automatic rand_gate(input int g);
        int p[4];
        for (int i = 0; i < 4; i++) p[i] = i;
        for (int i = 3; i > 0; i--) begin
            int k, t;
            k    = int'($urandom_range(0, i));
            t    = p[i];
            p[i] = p[k];
            p[k] = t;
        end
        gperm[g] = p;
        gneg[g]  = 4'($urandom);
    endtask

    task automatic rand_state();
        for (int i = 0; i < 4; i++) st_in[i] = rand_cx();
    endtask

    task automatic compute_exp(input int ng);
        logic [31:0] cur [4];
        logic [31:0] nxt [4];
        cur = st_in;
        for (int g = 0; g < ng; g++) begin
            for (int r = 0; r < 4; r++) begin
                nxt[r] = gneg[g][r] ? cneg(cur[gperm[g][r]])
                                    : cur[gperm[g][r]];
            end
            cur = nxt;
        end
        exp_out = cur;
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_load_ready"}, load_ready, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_last"}, out_last, 0);
        chk({nm, "_out_data"}, out_data, 0);
        chk({nm, "_mul_state"}, (mul_state === '0), 1);
        chk({nm, "_mul_gate"}, (mul_gate === '0), 1);
    endtask

    // rmode: 0 always ready, 1 random ready, 2 ready every other cycle
    task automatic run_op(input int ng, input bit rnd_v, input int rmode,
                          input bit abort, input string nm);
        int G, sent, cyc, napp, j;
        logic [3:0][31:0] packed_in;
        G = (ng > 4) ? 4 : ng;
        compute_exp(G);
        for (int i = 0; i < 4; i++) packed_in[i] = st_in[i];

        start     = 1'b1;
        num_gates = 3'(ng);
        step();
        start = 1'b0;
        chk({nm, "_busy_rise"}, busy, 1);

        sent = 0;
        cyc  = 0;
        while (sent < 4 && cyc < 200) begin
            load_valid = rnd_v ? ($urandom_range(0, 2) != 0) : 1'b1;
            load_data  = st_in[sent];
            if (load_valid && load_ready) sent++;
            step();
            cyc++;
        end
        load_valid = 1'b0;
        chk({nm, "_state_words"}, sent, 4);

        if (G == 0) begin
            chk({nm, "_readout_next"}, out_valid, 1);
            chk({nm, "_no_load"}, load_ready, 0);
        end else begin
            sent = 0;
            cyc  = 0;
            while (sent < G * 16 && cyc < 600) begin
                load_valid = rnd_v ? ($urandom_range(0, 2) != 0) : 1'b1;
                load_data  = gate_word(sent / 16, sent % 16);
                if (load_valid && load_ready) sent++;
                step();
                cyc++;
            end
            chk({nm, "_gate_words"}, sent, G * 16);
            load_valid = 1'b1;
            load_data  = $urandom;
            chk({nm, "_ready_drop"}, load_ready, 0);
            chk({nm, "_apply_state"}, (mul_state === packed_in), 1);

            if (abort) begin
                chk({nm, "_gate_driven"}, (mul_gate !== '0), 1);
                reset = 1'b0;
                #1;
                chk_idle_zero({nm, "_abort"});
                load_valid = 1'b0;
                step();
                reset = 1'b1;
                return;
            end

            napp = 0;
            while (!out_valid && napp < 100) begin
                napp++;
                step();
            end
            load_valid = 1'b0;
            chk({nm, "_apply_cycles"}, napp, 2 * G);
        end

        j   = 0;
        cyc = 0;
        while (j < 4 && cyc < 200) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom);
                default: out_ready = 1'(cyc % 2);
            endcase
            chk({nm, "_out_valid"}, out_valid, 1);
            chk({nm, "_out_data"}, out_data, exp_out[j]);
            chk({nm, "_out_last"}, out_last, (j == 3));
            if (out_ready && out_valid) j++;
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk({nm, "_transfers"}, j, 4);
        chk({nm, "_end_valid"}, out_valid, 0);
        chk({nm, "_end_busy"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        num_gates  = '0;
        load_valid = 1'b0;
        load_data  = '0;
        out_ready  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            start      = 1'($urandom);
            num_gates  = 3'($urandom);
            load_valid = 1'($urandom);
            load_data  = $urandom;
            out_ready  = 1'($urandom);
            step();
            chk_idle_zero("reset");
        end
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'($urandom);
            load_data  = $urandom;
            out_ready  = 1'($urandom);
            step();
            chk_idle_zero("idle");
        end
        load_valid = 1'b0;
        out_ready  = 1'b0;

        st_in = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        set_xx(0);
        run_op(1, 1'b0, 0, 1'b0, "s2");

        set_xx(0);
        set_xx(1);
        run_op(2, 1'b0, 0, 1'b0, "s3");

        st_in = '{32'h2D41_0000, 32'h0, 32'h0, 32'h2D41_0000};
        run_op(0, 1'b1, 1, 1'b0, "s4");

        rand_state();
        for (int g = 0; g < 4; g++) rand_gate(g);
        run_op(7, 1'b1, 2, 1'b0, "s5");

        st_in = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        set_xx(0);
        run_op(1, 1'b0, 0, 1'b1, "s6a");
        run_op(1, 1'b0, 0, 1'b0, "s6b");

        for (int t = 0; t < 6; t++) begin
            rand_state();
            for (int g = 0; g < 4; g++) rand_gate(g);
            run_op(int'($urandom_range(0, 5)), 1'b1, 1, 1'b0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
